// File: rtl/sq_param.sv
// sq_param: parametrised store queue with in-order drain to memory and age-ordered store-to-load forwarding.
// Define SQ_FLUSH_EN to compile in misprediction rollback of uncommitted stores; otherwise flush_i/flush_ptr_i are ignored.
module sq_param #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic              clk_2,
  input  logic              rstn,
  input  logic              alloc_valid_i,
  input  logic [PC_W-1:0]   alloc_pc_i,
  output logic [IDX_W-1:0]  alloc_idx_o,
  output logic [PTR_W-1:0]  alloc_ptr_o,
  input  logic              exe_we_i,
  input  logic [IDX_W-1:0]  exe_idx_i,
  input  logic [ADDR_W-1:0] exe_addr_i,
  input  logic [DATA_W-1:0] exe_data_i,
  input  logic              commit_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [PTR_W-1:0]  ld_age_i,
  output logic              ld_hit_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              ld_stall_o,
  input  logic              flush_i,
  input  logic [PTR_W-1:0]  flush_ptr_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [PTR_W-1:0]  count_o
);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} drain_e;

  drain_e            state_q;
  ptr_t              head_q, cmt_q, tail_q, tail_d;
  logic [DEPTH-1:0]  v_q, av_q;
  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  idx_t              head_idx, tail_idx;
  logic              alloc_fire, alloc_block, fill_fire, commit_fire, drain_start;
  logic              flush_ok;
  ptr_t              commit_lim;
  logic [DEPTH-1:0]  squash_mask;

  assign head_idx    = head_q[IDX_W-1:0];
  assign tail_idx    = tail_q[IDX_W-1:0];
  assign empty_o     = (head_q == tail_q);
  assign full_o      = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign count_o     = tail_q - head_q;
  assign alloc_idx_o = tail_idx;
  assign alloc_ptr_o = tail_q;

`ifdef SQ_FLUSH_EN
  // Legal rollback targets lie in [cmt, tail]; committed stores are never squashed.
  assign flush_ok    = flush_i && ((flush_ptr_i - cmt_q) <= (tail_q - cmt_q));
  assign alloc_block = flush_i;
  always_comb begin
    squash_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash_mask[i] = ({1'b0, idx_t'(i) - flush_ptr_i[IDX_W-1:0]} < (tail_q - flush_ptr_i));
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush_i ^ (^flush_ptr_i);
  assign flush_ok     = 1'b0;
  assign alloc_block  = 1'b0;
  assign squash_mask  = '0;
`endif

  assign alloc_fire  = alloc_valid_i && !full_o && !alloc_block;
  assign fill_fire   = exe_we_i && v_q[exe_idx_i];
  assign commit_lim  = flush_ok ? flush_ptr_i : tail_q;
  assign commit_fire = commit_i && (cmt_q != commit_lim);
  assign drain_start = (state_q == S_IDLE) && (head_q != cmt_q) && av_q[head_idx];

  always_comb begin
    tail_d = tail_q;
    if (flush_ok)        tail_d = flush_ptr_i;
    else if (alloc_fire) tail_d = tail_q + 1'b1;
  end

  always_ff @(posedge clk_2) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      cmt_q      <= '0;
      tail_q     <= '0;
      v_q        <= '0;
      av_q       <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      tail_q <= tail_d;
      if (alloc_fire) begin
        v_q[tail_idx]  <= 1'b1;
        av_q[tail_idx] <= 1'b0;
      end
      if (fill_fire) av_q[exe_idx_i] <= 1'b1;
      if (commit_fire) cmt_q <= cmt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (drain_start) begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= addr_q[head_idx];
            mem_data_o <= data_q[head_idx];
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            mem_req_o      <= 1'b0;
            v_q[head_idx]  <= 1'b0;
            av_q[head_idx] <= 1'b0;
            head_q         <= head_q + 1'b1;
            state_q        <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_ok && squash_mask[i]) begin
          v_q[i]  <= 1'b0;
          av_q[i] <= 1'b0;
        end
      end
    end
  end

  // Payload storage needs no reset: v/av gate every read.
  always_ff @(posedge clk_2) begin
    if (alloc_fire) pc_q[tail_idx] <= alloc_pc_i;
    if (fill_fire) begin
      addr_q[exe_idx_i] <= exe_addr_i;
      data_q[exe_idx_i] <= exe_data_i;
    end
  end

  logic unused_pc;
  always_comb begin
    unused_pc = 1'b0;
    for (int i = 0; i < DEPTH; i++) unused_pc = unused_pc ^ (^pc_q[i]);
  end

  ptr_t              fwd_span, fwd_off, fwd_best;
  logic              fwd_hit, fwd_stall;
  logic [DATA_W-1:0] fwd_data;

  // Age is the offset from head, so the youngest older match has the largest offset below ld_age.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    fwd_best  = '0;
    fwd_off   = '0;
    fwd_span  = ld_age_i - head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_off = {1'b0, idx_t'(i) - head_idx};
      if (v_q[i] && (fwd_off < fwd_span)) begin
        if (!av_q[i]) begin
          fwd_stall = 1'b1;
        end else if ((addr_q[i] == ld_addr_i) && (!fwd_hit || (fwd_off >= fwd_best))) begin
          fwd_hit  = 1'b1;
          fwd_best = fwd_off;
          fwd_data = data_q[i];
        end
      end
    end
  end

  assign ld_stall_o = ld_req_i && fwd_stall;
  assign ld_hit_o   = ld_req_i && fwd_hit && !fwd_stall;
  assign ld_data_o  = ld_hit_o ? fwd_data : '0;

endmodule

// File: tb/tb_sq_param.sv
// tb_sq_param: directed and randomized checks of sq_param against a sequence-number based store queue model.
module tb_sq_param;
  localparam int DEPTH = 64;
  localparam int IW    = 6;
  localparam int PW    = 7;
  localparam int PMOD  = 128;

  logic          clk_2 = 1'b0;
  logic          rstn  = 1'b0;
  logic          alloc_valid;
  logic [31:0]   alloc_pc;
  logic [IW-1:0] alloc_idx;
  logic [PW-1:0] alloc_ptr;
  logic          exe_we;
  logic [IW-1:0] exe_idx;
  logic [31:0]   exe_addr, exe_data;
  logic          commit;
  logic          mem_req;
  logic [31:0]   mem_addr, mem_data;
  logic          mem_ack;
  logic          ld_req;
  logic [31:0]   ld_addr;
  logic [PW-1:0] ld_age;
  logic          ld_hit;
  logic [31:0]   ld_data;
  logic          ld_stall;
  logic          flush;
  logic [PW-1:0] flush_ptr;
  logic          full, empty;
  logic [PW-1:0] count;

  sq_param #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .PC_W(32)) dut (
    .clk_2(clk_2), .rstn(rstn),
    .alloc_valid_i(alloc_valid), .alloc_pc_i(alloc_pc), .alloc_idx_o(alloc_idx), .alloc_ptr_o(alloc_ptr),
    .exe_we_i(exe_we), .exe_idx_i(exe_idx), .exe_addr_i(exe_addr), .exe_data_i(exe_data),
    .commit_i(commit),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_ack_i(mem_ack),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_age_i(ld_age),
    .ld_hit_o(ld_hit), .ld_data_o(ld_data), .ld_stall_o(ld_stall),
    .flush_i(flush), .flush_ptr_i(flush_ptr),
    .full_o(full), .empty_o(empty), .count_o(count)
  );

  always #5 clk_2 = ~clk_2;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: stores are numbered by absolute sequence; live stores are keys in [m_h, m_t).
  int          m_h, m_c, m_t;
  bit          m_req;
  logic [31:0] m_req_addr, m_req_data;
  logic [31:0] m_addr [int];
  logic [31:0] m_data [int];
  bit          m_av   [int];
  int          ld_age_abs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    alloc_valid = 0; alloc_pc = '0; exe_we = 0; exe_idx = '0; exe_addr = '0; exe_data = '0;
    commit = 0; mem_ack = 0; ld_req = 0; ld_addr = '0; ld_age_abs = 0; ld_age = '0;
    flush = 0; flush_ptr = '0;
  endtask

  task automatic model_reset();
    m_h = 0; m_c = 0; m_t = 0; m_req = 0; m_req_addr = '0; m_req_data = '0;
    m_addr.delete(); m_data.delete(); m_av.delete();
  endtask

  task automatic model_check();
    int          cnt;
    bit          st, ht;
    logic [31:0] d;
    cnt = m_t - m_h;
    chk("count", count, cnt);
    chk("full", full, cnt == DEPTH);
    chk("empty", empty, cnt == 0);
    chk("alloc_ptr", alloc_ptr, m_t % PMOD);
    chk("alloc_idx", alloc_idx, m_t % DEPTH);
    chk("mem_req", mem_req, m_req);
    if (m_req) begin
      chk("mem_addr", mem_addr, m_req_addr);
      chk("mem_data", mem_data, m_req_data);
    end
    st = 0; ht = 0; d = '0;
    if (ld_req) begin
      for (int s = ld_age_abs - 1; s >= m_h; s--) begin
        if (m_av.exists(s)) begin
          if (!m_av[s]) st = 1;
          else if (!ht && m_addr[s] == ld_addr) begin
            ht = 1; d = m_data[s];
          end
        end
      end
      if (st) begin ht = 0; d = '0; end
    end
    chk("ld_stall", ld_stall, st);
    chk("ld_hit", ld_hit, ht);
    chk("ld_data", ld_data, d);
  endtask

  task automatic model_update();
    bit full_m, dr_start, dr_done;
    int lim, new_t;
    full_m = (m_t - m_h) == DEPTH;
    dr_start = 0; dr_done = 0;
    lim = m_t; new_t = m_t;
    if (m_req) dr_done = mem_ack;
    else dr_start = (m_h != m_c) && m_av.exists(m_h) && m_av[m_h];
    if (dr_start) begin m_req_addr = m_addr[m_h]; m_req_data = m_data[m_h]; end
    if (exe_we) begin
      for (int s = m_h; s < m_t; s++) begin
        if ((s % DEPTH) == int'(exe_idx)) begin
          m_addr[s] = exe_addr; m_data[s] = exe_data; m_av[s] = 1;
        end
      end
    end
`ifdef SQ_FLUSH_EN
    if (flush) begin
      int fa;
      fa = m_c + ((int'(flush_ptr) - (m_c % PMOD) + PMOD) % PMOD);
      if (fa <= m_t) begin
        for (int s = fa; s < m_t; s++) begin
          m_av.delete(s); m_addr.delete(s); m_data.delete(s);
        end
        new_t = fa; lim = fa;
      end
    end
    if (alloc_valid && !full_m && !flush) begin m_av[m_t] = 0; new_t = m_t + 1; end
`else
    if (alloc_valid && !full_m) begin m_av[m_t] = 0; new_t = m_t + 1; end
`endif
    if (commit && m_c != lim) m_c++;
    if (dr_start) m_req = 1;
    if (dr_done) begin
      m_av.delete(m_h); m_addr.delete(m_h); m_data.delete(m_h);
      m_h++; m_req = 0;
    end
    m_t = new_t;
  endtask

  task automatic step();
    #1;
    model_check();
    @(posedge clk_2);
    model_update();
    @(negedge clk_2);
    set_idle();
    #1;
  endtask

  task automatic do_reset();
    rstn = 0;
    set_idle();
    @(posedge clk_2);
    model_reset();
    @(negedge clk_2);
    rstn = 1;
    #1;
  endtask

  task automatic set_ld(input int age, input logic [31:0] a);
    ld_req = 1; ld_age_abs = age; ld_age = PW'(age % PMOD); ld_addr = a;
  endtask

  initial begin
    set_idle();
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_alloc_ptr", alloc_ptr, 0);
    chk("rst_alloc_idx", alloc_idx, 0);
    chk("rst_ld_hit", ld_hit, 0);
    chk("rst_ld_stall", ld_stall, 0);
    step();

    // Fill to capacity, then one extra alloc must be dropped.
    for (int i = 0; i < DEPTH; i++) begin
      alloc_valid = 1; alloc_pc = 32'(i);
      step();
    end
    chk("cap_full", full, 1);
    chk("cap_count", count, 64);
    alloc_valid = 1;
    step();
    chk("cap_tail_held", alloc_ptr, 64);
    chk("cap_still_full", full, 1);

    // Youngest older match wins; a shorter age window sees the older store.
    do_reset();
    alloc_valid = 1; step();
    alloc_valid = 1; step();
    exe_we = 1; exe_idx = 0; exe_addr = 32'h40; exe_data = 32'h11; step();
    exe_we = 1; exe_idx = 1; exe_addr = 32'h40; exe_data = 32'h22; step();
    set_ld(2, 32'h40); #1;
    chk("fwd_age2_hit", ld_hit, 1);
    chk("fwd_age2_data", ld_data, 32'h22);
    step();
    set_ld(1, 32'h40); #1;
    chk("fwd_age1_hit", ld_hit, 1);
    chk("fwd_age1_data", ld_data, 32'h11);
    step();

    // Unknown older address stalls; a fill becomes visible only on the next cycle.
    do_reset();
    alloc_valid = 1; step();
    set_ld(1, 32'h80);
    exe_we = 1; exe_idx = 0; exe_addr = 32'h80; exe_data = 32'h5a; #1;
    chk("stall_set", ld_stall, 1);
    chk("stall_nohit", ld_hit, 0);
    step();
    set_ld(1, 32'h80); #1;
    chk("stall_clear", ld_stall, 0);
    chk("stall_fwd_data", ld_data, 32'h5a);
    step();

    // Drain with a 3-cycle ack delay holds the request and its payload.
    do_reset();
    alloc_valid = 1; step();
    exe_we = 1; exe_idx = 0; exe_addr = 32'h100; exe_data = 32'hdead; commit = 1; step();
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("drain_req_held", mem_req, 1);
      chk("drain_addr_held", mem_addr, 32'h100);
      chk("drain_data_held", mem_data, 32'hdead);
      step();
    end
    mem_ack = 1; step();
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    chk("drain_req_low", mem_req, 0);

    // Reset in the middle of a drain drops the request.
    do_reset();
    alloc_valid = 1; step();
    exe_we = 1; exe_idx = 0; exe_addr = 32'h104; exe_data = 32'h77; commit = 1; step();
    step();
    chk("mid_req_up", mem_req, 1);
    do_reset();
    chk("mid_rst_req", mem_req, 0);
    step();

    // Rollback: tail=5, cmt=2, head held by withholding ack.
    do_reset();
    for (int i = 0; i < 5; i++) begin alloc_valid = 1; step(); end
    for (int i = 0; i < 5; i++) begin
      exe_we = 1; exe_idx = IW'(i); exe_addr = 32'h200 + 32'(8 * i); exe_data = 32'(i + 1);
      step();
    end
    commit = 1; step();
    commit = 1; step();
    flush = 1; flush_ptr = 7'd3; step();
    set_ld(5, 32'h220); #1;
`ifdef SQ_FLUSH_EN
    chk("flush_tail", alloc_ptr, 3);
    chk("flush_squashed", ld_hit, 0);
`else
    chk("noflush_tail", alloc_ptr, 5);
    chk("noflush_hit", ld_data, 32'h5);
`endif
    step();
    flush = 1; flush_ptr = 7'd1; step();
`ifdef SQ_FLUSH_EN
    chk("flush_below_cmt", alloc_ptr, 3);
`else
    chk("noflush_tail2", alloc_ptr, 5);
`endif

    // Randomized traffic long enough to wrap the pointers several times.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      alloc_valid = ($urandom % 100) < 55;
      alloc_pc = $urandom;
      if (m_t > m_h && ($urandom % 100) < 70) begin
        exe_we = 1;
        exe_idx = IW'((m_h + int'($urandom % 32'(m_t - m_h))) % DEPTH);
      end else if (($urandom % 100) < 10) begin
        exe_we = 1;
        exe_idx = IW'($urandom % DEPTH);
      end
      exe_addr = 32'h40 + 32'(4 * ($urandom % 4));
      exe_data = $urandom;
      commit = ($urandom % 100) < 45;
      mem_ack = ($urandom % 100) < 60;
      if (($urandom % 100) < 80)
        set_ld(m_h + int'($urandom % 32'(m_t - m_h + 1)), 32'h40 + 32'(4 * ($urandom % 4)));
      flush = ($urandom % 100) < 4;
      flush_ptr = PW'((m_c + int'($urandom % 32'(m_t - m_c + 3))) % PMOD);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
